// File: rtl/latch_exerciser.sv
// Drives a D latch's data and gate with programmable square waves and counts
// cycles where the returned Q/nQ disagree with an internal reference latch.
module latch_exerciser #(
    parameter int CNT_W  = 8,
    parameter int ERR_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic             Clk,
    input  logic             nRst,
    input  logic             start,
    input  logic [CNT_W-1:0] d_half,
    input  logic [CNT_W-1:0] g_half,
    input  logic [CNT_W-1:0] n_cycles,
    input  logic             Q,
    input  logic             nQ,
    output logic             D,
    output logic             En,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [SW-1:0]    SET_ONE  = SW'(1);
    localparam logic [SW-1:0]    SET_LOAD = SW'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] dHalf_q, gHalf_q, nCycles_q;
    logic [CNT_W-1:0] dCnt_q, gCnt_q, perCnt_q;
    logic [SW-1:0]    settle_q, settle_d;
    logic [ERR_W-1:0] errCnt_q, errCnt_d;
    logic             dOut_q, dOut_d, enOut_q, enOut_d;
    logic             busy_q, done_q, expQ_q;
    logic             accept, dWrap, gWrap, lastFall, mismatch;

    always_comb begin
        accept   = (state_q == IDLE) && start && (d_half != '0) && (g_half != '0)
                   && (n_cycles != '0);
        dWrap    = (dCnt_q == dHalf_q - CNT_ONE);
        gWrap    = (gCnt_q == gHalf_q - CNT_ONE);
        lastFall = (state_q == RUN) && gWrap && enOut_q
                   && (perCnt_q + CNT_ONE == nCycles_q);

        dOut_d  = 1'b0;
        enOut_d = 1'b0;
        if ((state_q == RUN) && !lastFall) begin
            dOut_d  = dOut_q ^ dWrap;
            enOut_d = enOut_q ^ gWrap;
        end

        // Any edge on D or En (including the forced return to 0) blanks checking.
        settle_d = '0;
        if ((dOut_d != dOut_q) || (enOut_d != enOut_q)) begin
            settle_d = SET_LOAD;
        end else if (settle_q != '0) begin
            settle_d = settle_q - SET_ONE;
        end

        mismatch = (state_q == RUN) && (settle_q == '0)
                   && ((Q != expQ_q) || (nQ == Q));

        errCnt_d = errCnt_q;
        if (accept) begin
            errCnt_d = '0;
        end else if (mismatch && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + ERR_ONE;
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            dHalf_q   <= '0;
            gHalf_q   <= '0;
            nCycles_q <= '0;
            dCnt_q    <= '0;
            gCnt_q    <= '0;
            perCnt_q  <= '0;
            settle_q  <= '0;
            errCnt_q  <= '0;
            dOut_q    <= 1'b0;
            enOut_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            expQ_q    <= 1'b0;
        end else begin
            dOut_q   <= dOut_d;
            enOut_q  <= enOut_d;
            settle_q <= settle_d;
            errCnt_q <= errCnt_d;
            if (enOut_q) begin
                expQ_q <= dOut_q;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dHalf_q   <= d_half;
                        gHalf_q   <= g_half;
                        nCycles_q <= n_cycles;
                        dCnt_q    <= '0;
                        gCnt_q    <= '0;
                        perCnt_q  <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    dCnt_q <= dWrap ? '0 : dCnt_q + CNT_ONE;
                    gCnt_q <= gWrap ? '0 : gCnt_q + CNT_ONE;
                    if (gWrap && enOut_q) begin
                        perCnt_q <= perCnt_q + CNT_ONE;
                    end
                    if (lastFall) begin
                        dCnt_q   <= '0;
                        gCnt_q   <= '0;
                        perCnt_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign D       = dOut_q;
    assign En      = enOut_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = errCnt_q;
endmodule

// File: tb/tb_latch_exerciser.sv
// Scoreboard bench for latch_exerciser: a behavioural latch drives Q/nQ back and
// expected run length / error count come from a waveform-level reference model.
module tb_latch_exerciser;
    localparam int SETTLE  = 2;
    localparam int ERR_MAX = 15;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start;
    logic [7:0] dHalf, gHalf, nCycles;
    logic       q, nq, dOut, enOut, busy, done;
    logic [3:0] errCnt;
    logic       latchQ;
    int         latchMode;

    typedef struct {
        int len;
        int errs;
    } expect_t;
    expect_t sbQ[$];

    int checks     = 0;
    int errors     = 0;
    int busyCycles = 0;
    int modelExp   = 0;
    int lastErrs   = 0;

    latch_exerciser #(.CNT_W(8), .ERR_W(4), .SETTLE(SETTLE)) dut (
        .Clk(clk), .nRst(rstN), .start(start), .d_half(dHalf), .g_half(gHalf),
        .n_cycles(nCycles), .Q(q), .nQ(nq), .D(dOut), .En(enOut), .busy(busy),
        .done(done), .err_cnt(errCnt)
    );

    always #5 clk = ~clk;

    // Latch under test: mode 0 ideal, mode 1 Q stuck at 0, mode 2 nQ tied to Q.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) latchQ <= 1'b0;
        else if (enOut) latchQ <= dOut;
    end
    assign q  = (latchMode == 1) ? 1'b0 : latchQ;
    assign nq = (latchMode == 2) ? q : ~q;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic int waveAt(input int j, input int half, input int len);
        if (j >= len) return 0;
        return (j / half) % 2;
    endfunction

    // Walks the ideal D/En waveforms cycle by cycle after the accepting edge.
    task automatic modelRun(input int d, input int g, input int n, input int mode,
                            output int len, output int errs);
        int s, e, dp, ep, dj, ej;
        len  = 2 * g * n;
        s    = 0;
        e    = modelExp;
        errs = 0;
        for (int j = 1; j <= len; j++) begin
            dp = waveAt(j - 1, d, len);
            ep = waveAt(j - 1, g, len);
            if (s == 0 && (mode == 2 || (mode == 1 && e == 1))) errs++;
            if (ep == 1) e = dp;
            dj = waveAt(j, d, len);
            ej = waveAt(j, g, len);
            if (dj != dp || ej != ep) s = SETTLE;
            else if (s > 0) s--;
        end
        modelExp = e;
        if (errs > ERR_MAX) errs = ERR_MAX;
    endtask

    task automatic pushExpected(input int d, input int g, input int n, input int mode);
        expect_t x;
        int len, errs;
        modelRun(d, g, n, mode, len, errs);
        x.len  = len;
        x.errs = errs;
        sbQ.push_back(x);
        lastErrs = errs;
    endtask

    task automatic waitDone(input int cap);
        int t = 0;
        while (done !== 1'b1 && t < cap) begin
            @(negedge clk);
            t++;
        end
        checkOutput("done_seen", int'(done), 1);
    endtask

    task automatic applyStimulus(input int d, input int g, input int n, input int mode,
                                 input bit pokeMid);
        latchMode = mode;
        repeat (3) @(negedge clk);
        dHalf   = 8'(d);
        gHalf   = 8'(g);
        nCycles = 8'(n);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (d != 0 && g != 0 && n != 0) begin
            pushExpected(d, g, n, mode);
            checkOutput("busy_after_start", int'(busy), 1);
            if (pokeMid) begin
                repeat (2) @(negedge clk);
                dHalf   = 8'd1;
                gHalf   = 8'd1;
                nCycles = 8'd1;
                start   = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            waitDone(2 * g * n + 10);
            @(negedge clk);
            checkOutput("done_single", int'(done), 0);
            checkOutput("err_hold", int'(errCnt), lastErrs);
        end else begin
            repeat (2) @(negedge clk);
            checkOutput("ignored_busy", int'(busy), 0);
            checkOutput("ignored_err", int'(errCnt), lastErrs);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin : monitor
        expect_t e;
        if (!rstN) begin
            busyCycles = 0;
        end else begin
            if (busy) busyCycles++;
            if (done) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_done", int'(done), 0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("run_len", busyCycles, e.len);
                    checkOutput("err_cnt", int'(errCnt), e.errs);
                    checkOutput("busy_in_done", int'(busy), 0);
                    checkOutput("d_after_run", int'(dOut), 0);
                    checkOutput("en_after_run", int'(enOut), 0);
                end
                busyCycles = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN      = 1'b0;
        start     = 1'b0;
        dHalf     = 8'd0;
        gHalf     = 8'd0;
        nCycles   = 8'd0;
        latchMode = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_d", int'(dOut), 0);
        checkOutput("reset_en", int'(enOut), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_err", int'(errCnt), 0);
        rstN = 1'b1;

        applyStimulus(3, 4, 2, 0, 1'b0);
        applyStimulus(3, 4, 2, 1, 1'b0);
        applyStimulus(5, 8, 4, 2, 1'b0);
        applyStimulus(0, 4, 2, 0, 1'b0);
        applyStimulus(3, 4, 0, 0, 1'b0);
        applyStimulus(3, 4, 2, 0, 1'b1);
        applyStimulus(1, 1, 1, 0, 1'b0);

        // Start held across the DONE cycle: ignored there, accepted right after.
        latchMode = 0;
        @(negedge clk);
        dHalf   = 8'd2;
        gHalf   = 8'd2;
        nCycles = 8'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pushExpected(2, 2, 1, 0);
        waitDone(20);
        dHalf   = 8'd1;
        gHalf   = 8'd1;
        nCycles = 8'd1;
        start   = 1'b1;
        @(negedge clk);
        checkOutput("done_start_ignored", int'(busy), 0);
        pushExpected(1, 1, 1, 0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("after_done_start_busy", int'(busy), 1);
        waitDone(10);
        @(negedge clk);

        // Abort a run that is accumulating errors.
        latchMode = 2;
        repeat (3) @(negedge clk);
        dHalf   = 8'd7;
        gHalf   = 8'd8;
        nCycles = 8'd4;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("err_before_abort", int'(errCnt != 4'd0), 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("abort_d", int'(dOut), 0);
        checkOutput("abort_en", int'(enOut), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_err", int'(errCnt), 0);
        @(negedge clk);
        #1 rstN = 1'b1;
        modelExp = 0;
        lastErrs = 0;
        repeat (5) @(negedge clk);
        checkOutput("idle_after_abort", int'(busy), 0);
        applyStimulus(3, 4, 2, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int d, g, n, m;
            d = int'($urandom_range(6, 1));
            g = int'($urandom_range(5, 1));
            n = int'($urandom_range(3, 1));
            m = int'($urandom_range(2, 0));
            if (d == 1 && g == 1) m = 0;
            applyStimulus(d, g, n, m, 1'b0);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
